// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word over valid/ready
// and shifts it out one bit per enabled clock, MSB or LSB first.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             last;
  logic             accept;

  // Move the word one place toward the output end, zero-filling behind it.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign last       = (state == SHIFT) && (cnt == '0);
  // A new word may be taken during the final bit so frames run back to back.
  assign load_ready = !rst && ((state == IDLE) || (last && shift_en));
  assign accept     = load_valid && load_ready;
  assign done       = !rst && last && shift_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
    end else if (accept) begin
      state      <= SHIFT;
      cnt        <= CW'(WIDTH - 1);
      shreg      <= din;
      sout       <= out_bit(din);
      sout_valid <= 1'b1;
      busy       <= 1'b1;
    end else if ((state == SHIFT) && shift_en) begin
      shreg <= shift_word(shreg);
      if (last) begin
        state      <= IDLE;
        sout       <= 1'b0;
        sout_valid <= 1'b0;
        busy       <= 1'b0;
      end else begin
        cnt  <= cnt - 1'b1;
        sout <= out_bit(shift_word(shreg));
      end
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances share stimulus and are
// compared every cycle against a bit-queue model, plus literal frame checks.
module tb_piso_tx;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         load_valid = 1'b0;
  logic         shift_en = 1'b1;

  logic rdy_m, sout_m, sv_m, busy_m, done_m;
  logic rdy_l, sout_l, sv_l, busy_l, done_l;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  bit qm[$];
  bit ql[$];

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid), .load_ready(rdy_m),
    .shift_en(shift_en), .sout(sout_m), .sout_valid(sv_m), .busy(busy_m), .done(done_m));

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid), .load_ready(rdy_l),
    .shift_en(shift_en), .sout(sout_l), .sout_valid(sv_l), .busy(busy_l), .done(done_l));

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Model: each queue holds the frame bits still to be presented, head first.
  function automatic bit model_ready(input int n);
    return !rst && (n == 0 || (n == 1 && shift_en));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      qm.delete();
      ql.delete();
      chk_en = 1;
    end else begin
      bit acc;
      acc = load_valid && model_ready(qm.size());
      if (qm.size() > 0 && shift_en) void'(qm.pop_front());
      if (ql.size() > 0 && shift_en) void'(ql.pop_front());
      if (acc) begin
        for (int k = 0; k < W; k++) begin
          qm.push_back(din[W-1-k]);
          ql.push_back(din[k]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ready", rdy_m, model_ready(qm.size()));
      chk("m_sout",  sout_m, qm.size() > 0 ? qm[0] : 1'b0);
      chk("m_valid", sv_m, qm.size() > 0);
      chk("m_busy",  busy_m, qm.size() > 0);
      chk("m_done",  done_m, !rst && qm.size() == 1 && shift_en);
      chk("l_ready", rdy_l, model_ready(ql.size()));
      chk("l_sout",  sout_l, ql.size() > 0 ? ql[0] : 1'b0);
      chk("l_valid", sv_l, ql.size() > 0);
      chk("l_busy",  busy_l, ql.size() > 0);
      chk("l_done",  done_l, !rst && ql.size() == 1 && shift_en);
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic load_word(input logic [W-1:0] d);
    load_valid = 1'b1;
    din = d;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic collect(input int n, output logic [7:0] bm, output logic [7:0] bl,
                         output logic [7:0] dn);
    bm = '0; bl = '0; dn = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bm = {bm[6:0], sout_m};
      bl = {bl[6:0], sout_l};
      dn = {dn[6:0], done_m};
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [7:0] bm, bl, dn;

    // Reset held with a pending load: nothing accepted, outputs quiet.
    rst = 1'b1; load_valid = 1'b1; din = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_lit", rdy_m, 1'b0);
    chk("rst_valid_lit", sv_m, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; load_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready_lit", rdy_m, 1'b1);
    @(posedge clk); #1;

    // Single frames in both bit orders.
    load_word(4'b1011);
    collect(4, bm, bl, dn);
    chkv("frame1011_msb_lit", bm, 8'b0000_1011);
    chkv("frame1011_lsb_lit", bl, 8'b0000_1101);
    chkv("frame1011_done_lit", dn, 8'b0000_0001);
    load_word(4'b1000);
    collect(4, bm, bl, dn);
    chkv("frame1000_msb_lit", bm, 8'b0000_1000);
    chkv("frame1000_lsb_lit", bl, 8'b0000_0001);

    // Back-to-back frames with load_valid held high.
    load_valid = 1'b1; din = 4'b1100;
    @(posedge clk); #1;
    din = 4'b0011;
    bm = '0; bl = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bm = {bm[6:0], sout_m};
      bl = {bl[6:0], sout_l};
      if (i == 3) chk("b2b_ready_lit", rdy_m, 1'b1);
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bm = {bm[6:0], sout_m};
      bl = {bl[6:0], sout_l};
      if (i == 0) chk("b2b_busy_lit", busy_m, 1'b1);
      @(posedge clk); #1;
    end
    chkv("b2b_msb_lit", bm, 8'b1100_0011);
    chkv("b2b_lsb_lit", bl, 8'b0011_1100);

    // Stall at T+2 with an ignored load of 1111.
    load_word(4'b1010);
    collect(1, bm, bl, dn);
    shift_en = 1'b0; load_valid = 1'b1; din = 4'b1111;
    @(negedge clk);
    chk("stall_ready_lit", rdy_m, 1'b0);
    bm = {bm[6:0], sout_m};
    @(posedge clk); #1;
    shift_en = 1'b1; load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bm = {bm[6:0], sout_m};
      dn = {dn[6:0], done_m};
      @(posedge clk); #1;
    end
    chkv("stall_msb_lit", bm, 8'b0001_0010);
    chkv("stall_done_lit", dn, 8'b0000_0001);

    // Reset mid-frame, then a clean frame.
    load_word(4'b1111);
    collect(1, bm, bl, dn);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid_lit", sv_m, 1'b0);
    chk("midrst_busy_lit", busy_m, 1'b0);
    @(posedge clk); #1;
    load_word(4'b0110);
    collect(4, bm, bl, dn);
    chkv("after_rst_msb_lit", bm, 8'b0000_0110);
    chkv("after_rst_lsb_lit", bl, 8'b0000_0110);

    // Randomized traffic against the queue model.
    for (int c = 0; c < 600; c++) begin
      load_valid = ($urandom_range(0, 1) == 1);
      din = W'($urandom);
      shift_en = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 49) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; load_valid = 1'b0; shift_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per enabled clock. It is the transmit end of our serial-in/parallel-out capture register; with MSB_FIRST=1 and `sout` wired to that register's serial input, the register's parallel output equals the loaded word after WIDTH shifts. The block contains a registered shift path, a bit counter and a two-state FSM.

## Interface
- WIDTH, 4, word length in bits; must be 2 or greater.
- MSB_FIRST, 1, bit order: 1 sends din[WIDTH-1] first, 0 sends din[0] first.

Ports (name, direction, width, meaning):
- clk  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  word to transmit; sampled only on an accepted load.
- load_valid  input  1  din holds a word to send.
- load_ready  output  1  block can accept a word this cycle.
- shift_en  input  1  shift advance enable; 0 stalls the frame.
- sout  output  1  serial data, registered.
- sout_valid  output  1  sout carries a frame bit this cycle.
- busy  output  1  a frame is in progress (FSM in SHIFT).
- done  output  1  one-cycle pulse coinciding with the last bit of a frame.

## Operation
- A load is accepted in cycle T when load_valid and load_ready are both 1 at that rising edge.
- FSM states:
  - IDLE: no frame in progress.
  - SHIFT: frame in progress.
- Transitions:
  - IDLE to SHIFT on an accepted load.
  - SHIFT to IDLE after the last bit, if no new load is accepted.
  - SHIFT stays in SHIFT after the last bit if a new load is accepted (back-to-back frames).
- Bit counter `cnt` (width $clog2(WIDTH)):
  - Loaded with WIDTH-1 on accept.
  - Decrements on each enabled shift.
  - The last bit is the cycle in which cnt==0.
- Shift register:
  - On accept it captures din.
  - On each enabled shift it moves one position toward the output end: MSB end when MSB_FIRST=1, LSB end when MSB_FIRST=0. The vacated bit is filled with 0.
- load_ready = !rst && (state==IDLE || (state==SHIFT && cnt==0 && shift_en)). This is combinational, so a new word can be accepted during the last bit.
- Without a stall, a word accepted in cycle T drives bit k on sout during cycle T+1+k, for k=0..WIDTH-1.
- shift_en=0 in SHIFT:
  - sout, sout_valid, cnt and the shift register all hold.
  - The current bit is presented again; done does not fire.
  - Stall cycles add directly to frame length.
- shift_en is ignored in IDLE. Loads are accepted regardless of shift_en when IDLE.
- In IDLE, sout=0 and sout_valid=0.
- load_valid while load_ready=0 is ignored: no capture, and no effect on the current frame.

## Timing
- Reset values, in force from the first clock edge with rst=1: sout=0, sout_valid=0, busy=0, done=0, state=IDLE, cnt=0, shift register=0.
- load_ready is 0 while rst=1 and 1 in the first cycle after rst is deasserted.
- Latency: first bit appears 1 cycle after accept. Unstalled frame length is WIDTH cycles.
- sout_valid and busy are high for exactly the frame cycles, including stall cycles.
- done is high in the last-bit cycle only, and only if shift_en=1 in that cycle.
- Back-to-back: with a new accept during the last bit, the next frame's first bit follows with no gap. sout_valid stays high and busy does not drop.
- Reset mid-frame: the frame is aborted at that edge. All outputs take reset values, no done pulse is generated, and the word is lost.
- Simultaneous rst and load_valid: reset wins and nothing is accepted.
- din may change freely in any cycle other than the accept cycle.

## Test plan
- Reset/idle, WIDTH=4: assert rst for 2 cycles with load_valid=1 → sout=0, sout_valid=0, busy=0, done=0, load_ready=0. After release, load_ready=1.
- Single frame, MSB_FIRST=1, din=4'b1011 accepted at T → sout=1,0,1,1 in T+1..T+4; sout_valid=1 and busy=1 over T+1..T+4; done=1 only at T+4. Chained into the SIPO register, its out reads 4'b1011 after the edge ending T+4.
- LSB-first, MSB_FIRST=0, din=4'b1000 → sout=0,0,0,1; done at T+4.
- Back-to-back: 4'b1100, then 4'b0011 offered with load_valid held high → load_ready=1 at T and T+4. sout=1,1,0,0,0,0,1,1 continuously over T+1..T+8; done at T+4 and T+8; busy never drops.
- Stall and ignore: 4'b1010 with shift_en=0 at T+2 → sout=1,0,0,1,0 over T+1..T+5; done at T+5. A load_valid with din=4'b1111 during T+2 is ignored (load_ready=0), and the output sequence is unchanged.
- Reset mid-frame: rst=1 at T+2 during 4'b1111 → sout=0, sout_valid=0 and busy=0 from T+3; no done. A subsequent load of 4'b0110 transmits correctly.
